// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a sync_fifo and its producer/consumer.
// Error-flag signals exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush_i;
  logic                  we_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  re_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  empty_o;
  logic                  almost_empty_o;
  logic [ADDR_WIDTH:0]   fill_count_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, we_i, wdata_i, re_i,
    input  full_o, almost_full_o, rdata_o, empty_o, almost_empty_o, fill_count_o,
           overflow_o, underflow_o
  );
  modport slave (
    input  flush_i, we_i, wdata_i, re_i,
    output full_o, almost_full_o, rdata_o, empty_o, almost_empty_o, fill_count_o,
           overflow_o, underflow_o
  );
`else
  modport master (
    output flush_i, we_i, wdata_i, re_i,
    input  full_o, almost_full_o, rdata_o, empty_o, almost_empty_o, fill_count_o
  );
  modport slave (
    input  flush_i, we_i, wdata_i, re_i,
    output full_o, almost_full_o, rdata_o, empty_o, almost_empty_o, fill_count_o
  );
`endif
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, thresholds, flush and fill count.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow_o/underflow_o flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input logic        clk_i,
  input logic        rstn_i,
  sync_fifo_if.slave bus
);
  localparam int                  DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH-1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   fill;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  empty, full;
  logic                  wr_acc, rd_acc;

  // Extra pointer MSB makes the difference span 0..DEPTH, so the count needs no separate register.
  assign fill   = wptr_q - rptr_q;
  assign empty  = (fill == '0);
  assign full   = (fill == DEPTH_C);
  assign waddr  = wptr_q[ADDR_WIDTH-1:0];
  assign raddr  = rptr_q[ADDR_WIDTH-1:0];
  assign wr_acc = bus.we_i && !full;
  assign rd_acc = bus.re_i && !empty;

  assign bus.fill_count_o   = fill;
  assign bus.empty_o        = empty;
  assign bus.full_o         = full;
  assign bus.almost_full_o  = (fill >= AF_C);
  assign bus.almost_empty_o = (fill <= AE_C);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (bus.flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc && !bus.flush_i) mem_q[waddr] <= bus.wdata_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Gate with empty so the output reads 0 after reset/flush instead of stale memory.
    assign bus.rdata_o = empty ? '0 : mem_q[raddr];
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (bus.flush_i)  rdata_d = '0;
      else if (rd_acc)  rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) rdata_q <= '0;
      else         rdata_q <= rdata_d;
    end

    assign bus.rdata_o = rdata_q;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.flush_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (bus.we_i && full)  ovf_d = 1'b1;
      if (bus.re_i && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
`endif

endmodule
